// File: rtl/regwb_pkg.sv
// Shared types and default sizes for the register writeback arbiter.
package regwb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_CNT_W  = 2;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } gnt_src_e;

endpackage

// File: rtl/regwb_arbiter_if.sv
// Bundle of the writeback requesters, issue-stage and register-file write port signals.
interface regwb_arbiter_if
  import regwb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = DEF_NREGS
);
  logic              alu_valid_i;
  logic              alu_ready_o;
  logic [ADDR_W-1:0] alu_rd_i;
  logic [DATA_W-1:0] alu_data_i;
  logic              lsu_valid_i;
  logic              lsu_ready_o;
  logic [ADDR_W-1:0] lsu_rd_i;
  logic [DATA_W-1:0] lsu_data_i;
  logic              issue_valid_i;
  logic              issue_we_i;
  logic [ADDR_W-1:0] issue_rd_i;
  logic [ADDR_W-1:0] issue_rs1_i;
  logic [ADDR_W-1:0] issue_rs2_i;
  logic              issue_ready_o;
  logic              regs_wr_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_data_o;
  logic [NREGS-1:0]  busy_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  issue_valid_i, issue_we_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
    output alu_ready_o, lsu_ready_o, issue_ready_o,
    output regs_wr_en_o, rd_addr_o, rd_data_o, busy_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    output issue_valid_i, issue_we_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
    input  alu_ready_o, lsu_ready_o, issue_ready_o,
    input  regs_wr_en_o, rd_addr_o, rd_data_o, busy_o
  );
endinterface

// File: rtl/regwb_scoreboard.sv
// Per-register pending-write counters and the issue hazard check.
// REGWB_BYPASS_EN: a source whose single pending write is on the port this cycle does not stall.
module regwb_scoreboard
  import regwb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_issue_valid,
  input  logic              i_issue_we,
  input  logic [ADDR_W-1:0] i_issue_rd,
  input  logic [ADDR_W-1:0] i_issue_rs1,
  input  logic [ADDR_W-1:0] i_issue_rs2,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  output logic              o_issue_ready,
  output logic [NREGS-1:0]  o_busy
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt [NREGS];
  logic [NREGS-1:0] w_inc;
  logic [NREGS-1:0] w_dec;
  logic             w_inc_en;
  logic             w_rs1_haz;
  logic             w_rs2_haz;
  logic             w_rd_full;
  logic             w_rs1_byp;
  logic             w_rs2_byp;

  assign w_inc_en = i_issue_valid & o_issue_ready & i_issue_we & (i_issue_rd != '0);

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    assign w_inc[gi]  = w_inc_en && (i_issue_rd == ADDR_W'(gi));
    assign w_dec[gi]  = i_wr_en && (i_wr_addr == ADDR_W'(gi));
    assign o_busy[gi] = (r_cnt[gi] != '0);
  end

  // Coincident increment and decrement cancel; a decrement at zero is ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NREGS; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        if (w_inc[k] && !w_dec[k]) begin
          r_cnt[k] <= r_cnt[k] + CNT_ONE;
        end else if (w_dec[k] && !w_inc[k] && (r_cnt[k] != '0)) begin
          r_cnt[k] <= r_cnt[k] - CNT_ONE;
        end
      end
    end
  end

`ifdef REGWB_BYPASS_EN
  assign w_rs1_byp = (r_cnt[i_issue_rs1] == CNT_ONE) && i_wr_en && (i_wr_addr == i_issue_rs1);
  assign w_rs2_byp = (r_cnt[i_issue_rs2] == CNT_ONE) && i_wr_en && (i_wr_addr == i_issue_rs2);
`else
  assign w_rs1_byp = 1'b0;
  assign w_rs2_byp = 1'b0;
`endif

  assign w_rs1_haz = (i_issue_rs1 != '0) && (r_cnt[i_issue_rs1] != '0) && !w_rs1_byp;
  assign w_rs2_haz = (i_issue_rs2 != '0) && (r_cnt[i_issue_rs2] != '0) && !w_rs2_byp;
  assign w_rd_full = i_issue_we && (r_cnt[i_issue_rd] == CNT_MAX);

  assign o_issue_ready = !rst_i && !w_rs1_haz && !w_rs2_haz && !w_rd_full;

endmodule

// File: rtl/regwb_arbiter.sv
// Round-robin share of the register-file write port between ALU and LSU, plus issue scoreboard.
// Optional macro REGWB_BYPASS_EN enables same-cycle write-to-read hazard bypass in the scoreboard.
module regwb_arbiter
  import regwb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic           clk_i,
  input  logic           rst_i,
  regwb_arbiter_if.slave bus
);
  gnt_src_e          r_last_gnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_gnt_alu;
  logic              w_gnt_lsu;
  wb_req_t           w_req;

  // With both requesting, the one not served last wins.
  always_comb begin
    w_gnt_alu = 1'b0;
    w_gnt_lsu = 1'b0;
    if (!rst_i) begin
      if (bus.alu_valid_i && bus.lsu_valid_i) begin
        w_gnt_alu = (r_last_gnt == GNT_LSU);
        w_gnt_lsu = (r_last_gnt == GNT_ALU);
      end else begin
        w_gnt_alu = bus.alu_valid_i;
        w_gnt_lsu = bus.lsu_valid_i;
      end
    end
  end

  always_comb begin
    w_req.rd   = bus.alu_rd_i;
    w_req.data = bus.alu_data_i;
    if (w_gnt_lsu) begin
      w_req.rd   = bus.lsu_rd_i;
      w_req.data = bus.lsu_data_i;
    end
  end

  // x0 requests complete the handshake but never reach the register file.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_gnt <= GNT_LSU;
      r_wr_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_gnt_alu || w_gnt_lsu) begin
        r_last_gnt <= w_gnt_lsu ? GNT_LSU : GNT_ALU;
        if (w_req.rd != '0) begin
          r_wr_en   <= 1'b1;
          r_rd_addr <= w_req.rd;
          r_rd_data <= w_req.data;
        end
      end
    end
  end

  assign bus.alu_ready_o  = w_gnt_alu;
  assign bus.lsu_ready_o  = w_gnt_lsu;
  assign bus.regs_wr_en_o = r_wr_en;
  assign bus.rd_addr_o    = r_rd_addr;
  assign bus.rd_data_o    = r_rd_data;

  regwb_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .i_issue_valid (bus.issue_valid_i),
    .i_issue_we    (bus.issue_we_i),
    .i_issue_rd    (bus.issue_rd_i),
    .i_issue_rs1   (bus.issue_rs1_i),
    .i_issue_rs2   (bus.issue_rs2_i),
    .i_wr_en       (r_wr_en),
    .i_wr_addr     (r_rd_addr),
    .o_issue_ready (bus.issue_ready_o),
    .o_busy        (bus.busy_o)
  );

endmodule

// File: doc/regwb_arbiter.md
Name: regwb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: ALU/execute and LSU load-return.
- Keeps a per-register pending-write scoreboard so that issue is held off on read-after-write and write-after-write hazards.
- Sits between the execute/LSU stages and the register file write port (wr_en/rd_addr/rd_data).
- Also drives the stall to the issue stage.

Parameters:
- DATA_W, 32, width of the register data word.
- ADDR_W, 5, register index width.
- NREGS, 32, number of architectural registers; must equal 2**ADDR_W.
- CNT_W, 2, width of each register's pending-write counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- alu_valid_i  in  1  ALU writeback request.
- alu_ready_o  out  1  ALU request accepted this cycle.
- alu_rd_i  in  ADDR_W  ALU destination register.
- alu_data_i  in  DATA_W  ALU result.
- lsu_valid_i  in  1  LSU writeback request.
- lsu_ready_o  out  1  LSU request accepted this cycle.
- lsu_rd_i  in  ADDR_W  LSU destination register.
- lsu_data_i  in  DATA_W  load data.
- issue_valid_i  in  1  issue stage presents an instruction.
- issue_we_i  in  1  instruction writes rd.
- issue_rd_i  in  ADDR_W  destination register.
- issue_rs1_i  in  ADDR_W  source register 1.
- issue_rs2_i  in  ADDR_W  source register 2.
- issue_ready_o  out  1  instruction may issue; low means stall.
- regs_wr_en_o  out  1  register file write enable.
- rd_addr_o  out  ADDR_W  register file write address.
- rd_data_o  out  DATA_W  register file write data.
- busy_o  out  NREGS  bit k = counter k nonzero.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - All outputs 0: regs_wr_en_o, rd_addr_o, rd_data_o, busy_o.
  - All pending counters 0.
  - Round-robin pointer set to "last grant = LSU", so ALU wins first.
  - Pending writeback requests are dropped.
  - While rst_i is high, *_ready_o=0 and issue_ready_o=0.
- Arbitration (combinational):
  - Exactly one requester granted per cycle.
  - Single requester valid: it is granted.
  - Both valid: grant goes to the one not granted last.
  - Ready is asserted only to the granted requester; the pointer updates on grant.
  - Requesters hold valid/rd/data stable until ready.
- Output stage:
  - Grant registers rd/data into the output at the next edge; latency 1 cycle from handshake to regs_wr_en_o.
  - Output is valid for exactly one cycle per handshake; back-to-back grants give one write per cycle, with no bubble.
  - No grant: regs_wr_en_o=0; rd_addr_o/rd_data_o hold their last values.
- x0 handling:
  - A granted request with rd=0 completes its handshake but yields regs_wr_en_o=0.
  - rd=0 never touches any counter.
- Scoreboard counters:
  - Issue accepted (issue_valid_i & issue_ready_o & issue_we_i, rd≠0): counter[rd] increments.
  - Output write (regs_wr_en_o high, at that edge): counter[rd_addr_o] decrements.
  - Same edge, same register, increment and decrement: counter unchanged.
  - A decrement at zero is a protocol error; the counter stays 0.
- issue_ready_o is low when any of:
  - counter[rs1] ≠ 0 (rs1 ≠ 0);
  - counter[rs2] ≠ 0 (rs2 ≠ 0);
  - issue_we_i and counter[rd] is at maximum (2**CNT_W−1).
- x0 is never busy.

Optional Feature:
- Macro: REGWB_BYPASS_EN.
- Defined: a source register whose counter equals 1 and whose write is being presented this cycle (regs_wr_en_o & rd_addr_o==rs) is not a hazard. The register file makes write-then-read visible at the same edge, so this saves one stall cycle.
- Undefined: any nonzero counter stalls.

Decomposition:
- Package regwb_pkg holds:
  - DATA_W/ADDR_W/NREGS defaults;
  - the typedef of the writeback request struct {rd, data};
  - the enum for grant source {GNT_ALU, GNT_LSU}.
- Sub-module regwb_scoreboard holds the counter array, busy_o and the hazard/issue_ready logic.
- The top level holds the arbiter and output register.

Test Plan:
- Reset mid-write: assert rst_i while regs_wr_en_o=1, rd_addr_o=5 → all outputs 0 immediately, busy_o=0, the next ALU request is granted first.
- Simultaneous requests: ALU rd=3 data=0xAAAA_0001 and LSU rd=4 data=0x5555_0002 held valid → writes rd=3 then rd=4 on consecutive cycles; repeat → alternation continues.
- x0 write: ALU rd=0 data=0xFFFF_FFFF → alu_ready_o=1, regs_wr_en_o stays 0, busy_o unchanged.
- RAW stall: issue we rd=7; next issue rs1=7 → issue_ready_o=0 until the LSU write of rd=7 commits. Without the macro, issue resumes the cycle after regs_wr_en_o; with the macro, it resumes in the same cycle.
- WAW saturation: 3 accepted issues to rd=9 (CNT_W=2) with no writeback → the 4th issue to rd=9 is stalled; one write to rd=9 → the 4th issue is accepted.
- Simultaneous inc/dec: counter[2]=1; issue rd=2 in the same cycle as regs_wr_en_o rd=2 → counter[2] stays 1, busy_o[2]=1.
